axi_lite_slave_regs: RTL and testbench

- AXI4-Lite slave register bank that terminates the five AXI-Lite channels driven by the bench's write and read drivers.
- Provides NUM_REGS 32-bit read/write registers with byte-strobe writes and OKAY/SLVERR responses.
- Sits directly downstream of the AXI-Lite interface as the DUT endpoint; the write and read paths are independent state machines.

---
 rtl/axi_lite_pkg.sv | 20 ++
 rtl/axi_lite_regbank.sv | 70 +++++++
 rtl/axi_lite_slave_regs.sv | 191 +++++++++++++++++++
 tb/tb_axi_lite_slave_regs.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register slave: response codes and
// the write/read channel state encodings.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_W,
    W_WAIT_A,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

endpackage

// File: rtl/axi_lite_regbank.sv
// Register array behind the AXI4-Lite slave: byte-strobe write port,
// combinational read port and address range / error decode.
// Optional build macro: AXI_LITE_PROT_CHECK_EN -- when defined, unprivileged
// (prot[0]=0) accesses to index 0 are rejected with an error.
module axi_lite_regbank #(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [2:0]  wr_prot,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic        wr_err,
  input  logic [31:0] rd_addr,
  input  logic [2:0]  rd_prot,
  output logic [31:0] rd_data,
  output logic        rd_err
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [31:0] regs [NUM_REGS];
  logic [29:0] widx;
  logic [29:0] ridx;
  logic        w_oor;
  logic        r_oor;

  // Byte address low bits are ignored; the word index selects the register.
  assign widx  = wr_addr[31:2];
  assign ridx  = rd_addr[31:2];
  assign w_oor = (widx >= 30'(NUM_REGS));
  assign r_oor = (ridx >= 30'(NUM_REGS));

`ifdef AXI_LITE_PROT_CHECK_EN
  assign wr_err = w_oor | ((widx == '0) & ~wr_prot[0]);
  assign rd_err = r_oor | ((ridx == '0) & ~rd_prot[0]);
  logic unused_bits;
  assign unused_bits = ^{wr_addr[1:0], rd_addr[1:0], wr_prot[2:1], rd_prot[2:1]};
`else
  assign wr_err = w_oor;
  assign rd_err = r_oor;
  logic unused_bits;
  assign unused_bits = ^{wr_addr[1:0], rd_addr[1:0], wr_prot, rd_prot};
`endif

  // Read port: rejected reads return zero so no register contents leak out.
  always_comb begin
    rd_data = '0;
    if (!rd_err) rd_data = regs[ridx[IW-1:0]];
  end

  // Write port: only strobed bytes of an accepted, in-range write change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (wr_en && !wr_err) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (widx == 30'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave terminating AW/W/B and AR/R with independent write and
// read state machines in front of axi_lite_regbank. Build macro
// AXI_LITE_PROT_CHECK_EN (see axi_lite_regbank) enables the index-0
// protection check.
//
// state    | meaning
// W_IDLE   | ready for AW and W, either order or together
// W_WAIT_W | address latched, waiting for write data
// W_WAIT_A | data latched, waiting for write address
// W_RESP   | write response presented until bready
// R_IDLE   | ready for AR
// R_DATA   | read data presented until rready
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [2:0]  awprot,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [2:0]  arprot,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp
);

  wr_state_e   wr_state;
  rd_state_e   rd_state;
  logic [31:0] awaddr_q;
  logic [2:0]  awprot_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        commit;
  logic [31:0] c_addr;
  logic [2:0]  c_prot;
  logic [31:0] c_data;
  logic [3:0]  c_strb;
  logic        wr_err;
  logic [31:0] rd_data;
  logic        rd_err;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;

  // Commit operands: use the latched half when the other half arrives later.
  always_comb begin
    c_addr = awaddr;
    c_prot = awprot;
    c_data = wdata;
    c_strb = wstrb;
    commit = 1'b0;
    case (wr_state)
      W_IDLE:   commit = aw_hs & w_hs;
      W_WAIT_W: begin
        c_addr = awaddr_q;
        c_prot = awprot_q;
        commit = w_hs;
      end
      W_WAIT_A: begin
        c_data = wdata_q;
        c_strb = wstrb_q;
        commit = aw_hs;
      end
      default:  commit = 1'b0;
    endcase
  end

  axi_lite_regbank #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_regbank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (commit),
    .wr_addr (c_addr),
    .wr_prot (c_prot),
    .wr_data (c_data),
    .wr_strb (c_strb),
    .wr_err  (wr_err),
    .rd_addr (araddr),
    .rd_prot (arprot),
    .rd_data (rd_data),
    .rd_err  (rd_err)
  );

  // Write channel FSM with registered readies and response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state <= W_IDLE;
      awready  <= 1'b1;
      wready   <= 1'b1;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      awaddr_q <= '0;
      awprot_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            wr_state <= W_RESP;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b1;
            bresp    <= wr_err ? RESP_SLVERR : RESP_OKAY;
          end else if (aw_hs) begin
            wr_state <= W_WAIT_W;
            awready  <= 1'b0;
            awaddr_q <= awaddr;
            awprot_q <= awprot;
          end else if (w_hs) begin
            wr_state <= W_WAIT_A;
            wready   <= 1'b0;
            wdata_q  <= wdata;
            wstrb_q  <= wstrb;
          end
        end
        W_WAIT_W, W_WAIT_A: begin
          if (commit) begin
            wr_state <= W_RESP;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b1;
            bresp    <= wr_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
        W_RESP: begin
          if (bready) begin
            wr_state <= W_IDLE;
            awready  <= 1'b1;
            wready   <= 1'b1;
            bvalid   <= 1'b0;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM; data is sampled on the AR edge so a same-edge write is not seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= R_IDLE;
      arready  <= 1'b1;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state <= R_DATA;
            arready  <= 1'b0;
            rvalid   <= 1'b1;
            rdata    <= rd_data;
            rresp    <= rd_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
        R_DATA: begin
          if (rready) begin
            rd_state <= R_IDLE;
            arready  <= 1'b1;
            rvalid   <= 1'b0;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed bench for axi_lite_slave_regs: a vector table of single
// write/read transactions plus hand sequences for split, stalled, colliding
// and reset-interrupted transfers.
module tb_axi_lite_slave_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = 3'b001;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = 3'b001;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_lite_slave_regs #(.NUM_REGS(16), .RESET_VAL(32'h0)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // AW and W presented together; bvalid must appear exactly one cycle later.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    @(negedge clk);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s; bready = 1'b1;
    @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("wr_bvalid", 32'(bvalid), 32'd1);
    resp = bresp;
    @(posedge clk);
    @(negedge clk);
    check("wr_bvalid_clr", 32'(bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    @(negedge clk);
    arvalid = 1'b1; araddr = a; rready = 1'b1;
    @(posedge clk);
    #1 arvalid = 1'b0;
    @(negedge clk);
    check("rd_rvalid", 32'(rvalid), 32'd1);
    d = rdata;
    resp = rresp;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;

    vecs[0]  = '{1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 32'h04, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h3C, 32'h1234_5678, 4'hF, 2'b00, 32'h0};
    vecs[3]  = '{1'b0, 32'h3F, 32'h0,         4'h0, 2'b00, 32'h1234_5678};
    vecs[4]  = '{1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0};
    vecs[5]  = '{1'b0, 32'h40, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[6]  = '{1'b1, 32'h04, 32'h0,         4'h0, 2'b00, 32'h0};
    vecs[7]  = '{1'b0, 32'h04, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 32'h05, 32'h0,         4'h8, 2'b00, 32'h0};
    vecs[9]  = '{1'b0, 32'h04, 32'h0,         4'h0, 2'b00, 32'h00AD_BEEF};
    vecs[10] = '{1'b0, 32'h00, 32'h0,         4'h0, 2'b00, 32'h0};
    vecs[11] = '{1'b1, 32'hFFFF_FFFC, 32'hAAAA_AAAA, 4'hF, 2'b10, 32'h0};
    vecs[12] = '{1'b0, 32'h3C, 32'h0,         4'h0, 2'b00, 32'h1234_5678};

    // Reset state
    #12;
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready",  32'(wready),  32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_rdata",   rdata,        32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Vector table
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        check($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
      end else begin
        do_read(vecs[i].addr, d, resp);
        check($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
      end
    end

    // AW first, W three cycles later
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h08; bready = 1'b1;
    @(posedge clk);
    #1 awvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("awfirst_awready", 32'(awready), 32'd0);
      check("awfirst_wready",  32'(wready),  32'd1);
      check("awfirst_bvalid",  32'(bvalid),  32'd0);
    end
    wvalid = 1'b1; wdata = 32'h1122_3344; wstrb = 4'b0101;
    @(posedge clk);
    #1 wvalid = 1'b0;
    @(negedge clk);
    check("awfirst_bvalid1", 32'(bvalid), 32'd1);
    check("awfirst_bresp",   32'(bresp),  32'd0);
    @(posedge clk);
    do_read(32'h08, d, resp);
    check("awfirst_rdata", d, 32'h0022_0044);

    // W first, bready held low for 5 cycles
    @(negedge clk);
    wvalid = 1'b1; wdata = 32'h0000_0055; wstrb = 4'hF; bready = 1'b0;
    @(posedge clk);
    #1 wvalid = 1'b0;
    @(negedge clk);
    check("wfirst_wready",  32'(wready),  32'd0);
    check("wfirst_awready", 32'(awready), 32'd1);
    awvalid = 1'b1; awaddr = 32'h10;
    @(posedge clk);
    #1 awvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_bvalid",  32'(bvalid),  32'd1);
      check("stall_bresp",   32'(bresp),   32'd0);
      check("stall_awready", 32'(awready), 32'd0);
      check("stall_wready",  32'(wready),  32'd0);
    end
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall_bvalid_clr", 32'(bvalid),  32'd0);
    check("stall_awready1",   32'(awready), 32'd1);
    do_read(32'h10, d, resp);
    check("wfirst_rdata", d, 32'h0000_0055);

    // Write and read of the same register on the same edge
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h0C; wvalid = 1'b1; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h0C; bready = 1'b1; rready = 1'b1;
    @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("coll_bvalid", 32'(bvalid), 32'd1);
    check("coll_rvalid", 32'(rvalid), 32'd1);
    check("coll_rdata_old", rdata, 32'h0);
    @(posedge clk);
    do_read(32'h0C, d, resp);
    check("coll_rdata_new", d, 32'hA5A5_A5A5);

    // Reset with AW latched and read data pending
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h04; arvalid = 1'b1; araddr = 32'h04; rready = 1'b0;
    @(posedge clk);
    #1 awvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("mid_awready_pre", 32'(awready), 32'd0);
    check("mid_rvalid_pre",  32'(rvalid),  32'd1);
    rst = 1'b0;
    #1;
    check("mid_bvalid",  32'(bvalid),  32'd0);
    check("mid_rvalid",  32'(rvalid),  32'd0);
    check("mid_awready", 32'(awready), 32'd1);
    check("mid_wready",  32'(wready),  32'd1);
    check("mid_arready", 32'(arready), 32'd1);
    @(negedge clk);
    rst = 1'b1; rready = 1'b1;
    do_read(32'h04, d, resp);
    check("mid_reg1", d, 32'h0);
    do_read(32'h0C, d, resp);
    check("mid_reg3", d, 32'h0);
    do_read(32'h3C, d, resp);
    check("mid_reg15", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
